intc_benes_pipe: RTL and testbench

- Fully pipelined, parametrised Benes permutation network between buffer RAM slots and FHE ALU modules.
- Successor to the fixed 32-lane interconnect: generalised lane count (2^LOG2N), independent input/output port counts with zero padding and truncation, and valid-qualified beats.
- Adds double-buffered switch configuration loaded over a ready/valid port and committed atomically; every beat carries its bank tag, so reconfiguration never corrupts in-flight data.
- Parent instantiates one per direction (RAM-to-module, module-to-RAM).

---
 rtl/intc_benes_pipe.sv | 126 ++++++++++++
 tb/tb_intc_benes_pipe.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/intc_benes_pipe.sv
// intc_benes_pipe: pipelined Benes permutation network with double-buffered,
// bank-tagged switch configuration so reconfiguration never disturbs in-flight beats.
module intc_benes_pipe #(
    parameter int DATA_WIDTH = 512,
    parameter int LOG2N      = 5,
    parameter int IN_PORTS   = 20,
    parameter int OUT_PORTS  = 20,
    localparam int N         = 1 << LOG2N,
    localparam int STAGES    = 2 * LOG2N - 1,
    localparam int SW        = N / 2,
    localparam int LAT       = 2 * LOG2N + 1,
    localparam int STW       = $clog2(STAGES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data [0:IN_PORTS-1],
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data [0:OUT_PORTS-1],
    output logic                  o_bank,
    input  logic                  i_cfg_valid,
    output logic                  o_cfg_ready,
    input  logic [STW-1:0]        i_cfg_stage,
    input  logic [SW-1:0]         i_cfg_word,
    input  logic                  i_cfg_commit,
    output logic                  o_active_bank,
    output logic                  o_cfg_err
);
    localparam int CW = $clog2(LAT + 1);

    // lane_q[0] is the input register, lane_q[s+1] holds the output of stage s
    logic [DATA_WIDTH-1:0] lane_q [0:STAGES][0:N-1];
    logic [DATA_WIDTH-1:0] lane_d [0:STAGES][0:N-1];
    logic [STAGES:0]       valid_q, valid_d, tag_q, tag_d;
    logic [SW-1:0]         bank_q [0:1][0:STAGES-1];
    logic                  active_q, err_q, err_d, rdy, wr_ok, cm_ok;
    logic [CW-1:0]         cnt_q, cnt_d;

    genvar k, s, j;
    generate
        for (k = 0; k < N; k++) begin : g_in
            if (k < IN_PORTS) begin : g_real
                assign lane_d[0][k] = i_data[k];
            end else begin : g_pad
                assign lane_d[0][k] = '0;
            end
        end
        for (s = 0; s < STAGES; s++) begin : g_st
            localparam int B = (s < LOG2N) ? LOG2N - 1 - s : s - LOG2N + 1;
            for (j = 0; j < SW; j++) begin : g_sw
                localparam int LO = ((j >> B) << (B + 1)) | (j & ((1 << B) - 1));
                localparam int HI = LO + (1 << B);
                logic x;
                assign x = bank_q[tag_q[s]][s][j];
                assign lane_d[s+1][LO] = x ? lane_q[s][HI] : lane_q[s][LO];
                assign lane_d[s+1][HI] = x ? lane_q[s][LO] : lane_q[s][HI];
            end
        end
    endgenerate

    assign valid_d = {valid_q[STAGES-1:0], i_valid};
    assign tag_d   = {tag_q[STAGES-1:0], active_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            tag_q   <= '0;
            for (int p = 0; p <= STAGES; p++)
                for (int q = 0; q < N; q++)
                    lane_q[p][q] <= '0;
        end else begin
            valid_q <= valid_d;
            for (int p = 0; p <= STAGES; p++)
                if (valid_d[p]) begin
                    tag_q[p] <= tag_d[p];
                    for (int q = 0; q < N; q++)
                        lane_q[p][q] <= lane_d[p][q];
                end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_bank  <= 1'b0;
            for (int p = 0; p < OUT_PORTS; p++)
                o_data[p] <= '0;
        end else begin
            o_valid <= valid_q[STAGES];
            if (valid_q[STAGES]) begin
                o_bank <= tag_q[STAGES];
                for (int p = 0; p < OUT_PORTS; p++)
                    o_data[p] <= lane_q[STAGES][p];
            end
        end
    end

    assign rdy   = cnt_q == '0;
    assign wr_ok = i_cfg_valid & rdy & (i_cfg_stage < STW'(STAGES));
    assign cm_ok = i_cfg_commit & rdy;
    assign err_d = rdy ? (i_cfg_valid & ~wr_ok) : (i_cfg_valid | i_cfg_commit);
    assign cnt_d = cm_ok ? CW'(LAT) : (rdy ? cnt_q : cnt_q - CW'(1));

    // A write and commit in the same cycle both target the pre-toggle shadow bank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            for (int b = 0; b < 2; b++)
                for (int p = 0; p < STAGES; p++)
                    bank_q[b][p] <= '0;
        end else begin
            active_q <= active_q ^ cm_ok;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            for (int p = 0; p < STAGES; p++)
                if (wr_ok && i_cfg_stage == STW'(p))
                    bank_q[~active_q][p] <= i_cfg_word;
        end
    end

    assign o_cfg_ready   = rdy;
    assign o_active_bank = active_q;
    assign o_cfg_err     = err_q;
endmodule

// File: tb/tb_intc_benes_pipe.sv
// tb_intc_benes_pipe: randomized traffic and config against a cycle-indexed
// scoreboard that routes each beat through the Benes rules when it enters.
module tb_intc_benes_pipe;
    localparam int DW = 512, NI = 20, NO = 20, N = 32, ST = 9, LAT = 11;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          i_valid, o_valid, o_bank, i_cfg_valid, o_cfg_ready;
    logic          i_cfg_commit, o_active_bank, o_cfg_err;
    logic [DW-1:0] i_data [0:NI-1];
    logic [DW-1:0] o_data [0:NO-1];
    logic [3:0]    i_cfg_stage;
    logic [15:0]   i_cfg_word;

    intc_benes_pipe dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_data(i_data),
        .o_valid(o_valid), .o_data(o_data), .o_bank(o_bank),
        .i_cfg_valid(i_cfg_valid), .o_cfg_ready(o_cfg_ready),
        .i_cfg_stage(i_cfg_stage), .i_cfg_word(i_cfg_word),
        .i_cfg_commit(i_cfg_commit), .o_active_bank(o_active_bank),
        .o_cfg_err(o_cfg_err)
    );

    int            n_chk, n_pass, cyc, low_cnt;
    logic [15:0]   m_bank [2][ST];
    bit            m_act, m_err, act_mark;
    int            m_cnt;
    int            perm [N];
    bit            r_v [64];
    bit            r_b [64];
    logic [DW-1:0] r_d [64][NO];
    bit            l_b;
    logic [DW-1:0] l_d [NO];

    task automatic check(string tag, logic [DW-1:0] got, logic [DW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // perm[lane] = input index found on that lane after all stages
    function automatic void route(bit bk);
        int b, lo, hi, t;
        for (int k = 0; k < N; k++) perm[k] = k;
        for (int s = 0; s < ST; s++) begin
            b = (s < 5) ? 4 - s : s - 4;
            for (int j = 0; j < N / 2; j++) begin
                lo = ((j >> b) << (b + 1)) | (j & ((1 << b) - 1));
                hi = lo + (1 << b);
                if (m_bank[bk][s][j]) begin
                    t = perm[lo]; perm[lo] = perm[hi]; perm[hi] = t;
                end
            end
        end
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 64; i++) begin
            r_v[i] = 0; r_b[i] = 0;
            for (int p = 0; p < NO; p++) r_d[i][p] = '0;
        end
        for (int p = 0; p < NO; p++) l_d[p] = '0;
        for (int s = 0; s < ST; s++) begin m_bank[0][s] = '0; m_bank[1][s] = '0; end
        l_b = 0; m_act = 0; m_cnt = 0; m_err = 0;
    endtask

    task automatic cycle();
        int slot;
        bit rdy;
        slot = (cyc + LAT) % 64;
        rdy = (m_cnt == 0);
        r_v[slot] = i_valid;
        r_b[slot] = m_act;
        if (i_valid) begin
            route(m_act);
            for (int p = 0; p < NO; p++)
                if (perm[p] < NI) r_d[slot][p] = i_data[perm[p]];
                else r_d[slot][p] = '0;
        end
        m_err = rdy ? (i_cfg_valid && i_cfg_stage >= ST) : (i_cfg_valid || i_cfg_commit);
        if (rdy && i_cfg_valid && i_cfg_stage < ST) m_bank[!m_act][i_cfg_stage] = i_cfg_word;
        if (rdy && i_cfg_commit) begin m_act = !m_act; m_cnt = LAT; end
        else if (m_cnt > 0) m_cnt--;
        @(posedge clk); #1;
        cyc++;
        slot = cyc % 64;
        if (r_v[slot]) begin
            l_b = r_b[slot];
            for (int p = 0; p < NO; p++) l_d[p] = r_d[slot][p];
        end
        check("o_valid", o_valid, r_v[slot]);
        r_v[slot] = 0;
        check("o_bank", o_bank, l_b);
        check("o_cfg_err", o_cfg_err, m_err);
        check("o_active_bank", o_active_bank, m_act);
        check("o_cfg_ready", o_cfg_ready, m_cnt == 0);
        for (int p = 0; p < NO; p++) check($sformatf("o_data[%0d]", p), o_data[p], l_d[p]);
    endtask

    task automatic quiet();
        i_valid = 0; i_cfg_valid = 0; i_cfg_commit = 0;
    endtask

    task automatic idle(int n);
        quiet();
        repeat (n) cycle();
    endtask

    task automatic beat_seq();
        i_valid = 1;
        for (int p = 0; p < NI; p++) i_data[p] = DW'(p + 1);
        cycle();
        i_valid = 0;
    endtask

    task automatic wr(int st, logic [15:0] w);
        i_cfg_valid = 1; i_cfg_stage = 4'(st); i_cfg_word = w;
        cycle();
        i_cfg_valid = 0;
    endtask

    task automatic commit();
        i_cfg_commit = 1;
        cycle();
        i_cfg_commit = 0;
    endtask

    task automatic rnd_data();
        for (int p = 0; p < NI; p++)
            for (int w = 0; w < DW / 32; w++) i_data[p][w*32 +: 32] = $urandom;
    endtask

    initial begin
        n_chk = 0; n_pass = 0; cyc = 0; low_cnt = 0;
        quiet(); i_cfg_stage = '0; i_cfg_word = '0;
        for (int p = 0; p < NI; p++) i_data[p] = '0;
        m_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        check("rst_valid", o_valid, 0);
        check("rst_ready", o_cfg_ready, 1);
        check("rst_active", o_active_bank, 0);
        check("rst_err", o_cfg_err, 0);
        check("rst_bank", o_bank, 0);
        check("rst_data", o_data[0], 0);

        // identity routing
        idle(4);
        beat_seq();
        idle(10);
        check("id_valid", o_valid, 1);
        check("id_lane0", o_data[0], 1);
        check("id_lane19", o_data[19], 20);
        check("id_bank", o_bank, 0);
        idle(1);
        check("id_single", o_valid, 0);

        // stage 0 fully crossed
        wr(0, 16'hFFFF);
        for (int s = 1; s < ST; s++) wr(s, 16'h0000);
        commit();
        idle(12);
        beat_seq();
        idle(10);
        check("x0_lane0", o_data[0], 17);
        check("x0_lane3", o_data[3], 20);
        check("x0_lane4", o_data[4], 0);
        check("x0_lane15", o_data[15], 0);
        check("x0_lane16", o_data[16], 1);
        check("x0_lane19", o_data[19], 4);
        check("x0_bank", o_bank, 1);

        // commit during traffic, rejected commit while draining, held write
        for (int s = 0; s < ST; s++) wr(s, 16'($urandom));
        idle(2);
        for (int i = 0; i < 30; i++) begin
            rnd_data();
            i_valid = 1;
            i_cfg_commit = (i == 5) || (i == 8);
            i_cfg_valid = (i >= 10) && (i <= 17);
            i_cfg_stage = 4'd3; i_cfg_word = 16'hA5A5;
            cycle();
            if (!o_cfg_ready) low_cnt++;
            if (i == 5) act_mark = o_active_bank;
            if (i == 8) begin
                check("drain_commit_err", o_cfg_err, 1);
                check("drain_commit_bank", o_active_bank, act_mark);
            end
            if (i == 16) check("held_write_rej", o_cfg_err, 1);
            if (i == 17) check("held_write_acc", o_cfg_err, 0);
        end
        check("drain_len", low_cnt, 11);
        idle(12);

        // out-of-range stage writes
        wr(9, 16'h1234);
        check("bad_stage9", o_cfg_err, 1);
        wr(15, 16'h4321);
        check("bad_stage15", o_cfg_err, 1);
        commit();
        idle(12);

        // valid pattern 1,1,0,1
        for (int i = 0; i < 40; i++) begin
            rnd_data();
            i_valid = (i % 4) != 2;
            cycle();
        end
        idle(12);

        // random traffic and configuration
        for (int i = 0; i < 400; i++) begin
            rnd_data();
            i_valid = ($urandom % 4) != 0;
            i_cfg_valid = ($urandom % 4) == 0;
            i_cfg_stage = 4'($urandom % 12);
            i_cfg_word = 16'($urandom);
            i_cfg_commit = ($urandom % 16) == 0;
            cycle();
        end
        idle(12);

        // reset with beats in flight
        for (int i = 0; i < 6; i++) begin
            rnd_data();
            i_valid = 1;
            cycle();
        end
        quiet();
        rst_n = 0;
        #1;
        check("mid_rst_valid", o_valid, 0);
        m_reset();
        @(posedge clk); #1;
        rst_n = 1;
        check("mid_rst_active", o_active_bank, 0);
        check("mid_rst_ready", o_cfg_ready, 1);
        idle(2);
        beat_seq();
        idle(10);
        check("mid_rst_id5", o_data[5], 6);
        check("mid_rst_bank", o_bank, 0);
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
